dmem_responder: RTL and testbench

- Memory-side responder for the core's load/store port; it is the target that data accesses are sent to.
- Accepts one request at a time over a valid/ready handshake and applies RV32I byte/half/word semantics from funct3.
- Inserts a configurable number of wait states, then returns read data or an error over a second valid/ready handshake.
- Sits between the datapath (or a future multi-cycle core) and word-organised data storage.

---
 rtl/dmem_pkg.sv | 26 ++
 rtl/dmem_lane_align.sv | 60 ++++++
 rtl/dmem_responder.sv | 123 ++++++++++++
 tb/tb_dmem_responder.sv | 401 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory responder: funct3 codes, FSM states
// and the alignment rule used by both the lane logic and the top level.
package dmem_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    // Halves must sit on even addresses, words on multiples of four.
    function automatic logic misaligned(input logic [2:0] funct3, input logic [1:0] offset);
        case (funct3)
            F3_H, F3_HU: misaligned = offset[0];
            F3_W:        misaligned = (offset != 2'b00);
            default:     misaligned = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Combinational RV32I lane logic: merges store data into the old word and
// extracts/extends load data, flagging misaligned or illegal accesses.
module dmem_lane_align
    import dmem_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  offset,
    input  logic        is_write,
    input  logic [31:0] old_word,
    input  logic [31:0] wdata,
    output logic [31:0] new_word,
    output logic [31:0] load_data,
    output logic        error
);

    logic [4:0]  byte_shift;
    logic [4:0]  half_shift;
    logic [7:0]  byte_val;
    logic [15:0] half_val;

    assign byte_shift = {offset, 3'b000};
    assign half_shift = {offset[1], 4'b0000};
    assign byte_val   = old_word[byte_shift +: 8];
    assign half_val   = old_word[half_shift +: 16];

    always_comb begin
        new_word  = old_word;
        load_data = '0;
        error     = misaligned(funct3, offset);
        case (funct3)
            F3_B: begin
                load_data = {{24{byte_val[7]}}, byte_val};
                new_word[byte_shift +: 8] = wdata[7:0];
            end
            F3_H: begin
                load_data = {{16{half_val[15]}}, half_val};
                new_word[half_shift +: 16] = wdata[15:0];
            end
            F3_W: begin
                load_data = old_word;
                new_word  = wdata;
            end
            // Unsigned variants exist only for loads.
            F3_BU: begin
                load_data = {24'b0, byte_val};
                error     = error | is_write;
            end
            F3_HU: begin
                load_data = {16'b0, half_val};
                error     = error | is_write;
            end
            default: error = 1'b1;
        endcase
        if (error) begin
            new_word  = old_word;
            load_data = '0;
        end
    end

endmodule

// File: rtl/dmem_responder.sv
// Memory-side responder for the core's load/store port: one request at a time,
// fixed wait states, then a registered response held until it is accepted.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int    ADDR_WIDTH  = 32,
    parameter int    DATA_WIDTH  = 32,
    parameter int    DEPTH_LOG2  = 10,
    parameter int    WAIT_STATES = 2,
    parameter string PATH        = "dMem.bin"
) (
    input  logic                  clock,
    input  logic                  rstn,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [2:0]            req_funct3,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_error
);

    localparam int    WORDS       = 1 << DEPTH_LOG2;
    localparam string unused_path = PATH;

    state_t                  state;
    state_t                  state_next;
    logic [3:0]              wait_cnt;
    logic                    wr_q;
    logic [DEPTH_LOG2-1:0]   idx_q;
    logic [1:0]              off_q;
    logic [2:0]              f3_q;
    logic [DATA_WIDTH-1:0]   wdata_q;
    logic [DATA_WIDTH-1:0]   mem [WORDS];
    logic                    accept;
    logic                    access;
    logic [31:0]             new_word;
    logic [31:0]             load_data;
    logic                    lane_error;
    logic                    req_ready_next;
    logic                    rsp_valid_next;
    logic                    unused_addr;

    // Address bits above the storage index are ignored, so accesses wrap.
    assign unused_addr = ^req_addr[ADDR_WIDTH-1:DEPTH_LOG2+2];

    assign accept = req_valid && req_ready;
    assign access = (state == ST_WAIT) && (wait_cnt == 4'd0);

    always_ff @(posedge clock or negedge rstn) begin
        if (!rstn) state <= ST_IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: if (accept)                 state_next = ST_WAIT;
            ST_WAIT: if (wait_cnt == 4'd0)       state_next = ST_RESP;
            ST_RESP: if (rsp_valid && rsp_ready) state_next = ST_IDLE;
            default:                             state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        req_ready_next = (state_next == ST_IDLE);
        rsp_valid_next = (state_next == ST_RESP);
    end

    dmem_lane_align u_lane_align (
        .funct3    (f3_q),
        .offset    (off_q),
        .is_write  (wr_q),
        .old_word  (mem[idx_q]),
        .wdata     (wdata_q),
        .new_word  (new_word),
        .load_data (load_data),
        .error     (lane_error)
    );

    // Handshake outputs are registered from the next state so nothing on the
    // request or response inputs reaches an output combinationally.
    always_ff @(posedge clock or negedge rstn) begin
        if (!rstn) begin
            req_ready <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_error <= 1'b0;
            wait_cnt  <= 4'd0;
            wr_q      <= 1'b0;
            idx_q     <= '0;
            off_q     <= 2'b00;
            f3_q      <= 3'b000;
            wdata_q   <= '0;
        end else begin
            req_ready <= req_ready_next;
            rsp_valid <= rsp_valid_next;
            if (accept) begin
                wr_q     <= req_write;
                idx_q    <= req_addr[DEPTH_LOG2+1:2];
                off_q    <= req_addr[1:0];
                f3_q     <= req_funct3;
                wdata_q  <= req_wdata;
                wait_cnt <= 4'(WAIT_STATES);
            end else if ((state == ST_WAIT) && (wait_cnt != 4'd0)) begin
                wait_cnt <= wait_cnt - 4'd1;
            end
            if (access) begin
                rsp_rdata <= (wr_q || lane_error) ? '0 : load_data;
                rsp_error <= lane_error;
            end
        end
    end

    // Storage is never reset; a store lands only on the cycle it leaves WAIT.
    always_ff @(posedge clock) begin
        if (access && wr_q && !lane_error) mem[idx_q] <= new_word;
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed self-checking bench for dmem_responder with WAIT_STATES=2.
module tb_dmem_responder;

    logic        clock;
    logic        rstn;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [31:0] req_addr;
    logic [2:0]  req_funct3;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_error;

    int vectors;
    int miscompares;

    dmem_responder #(
        .ADDR_WIDTH  (32),
        .DATA_WIDTH  (32),
        .DEPTH_LOG2  (10),
        .WAIT_STATES (2)
    ) dut (
        .clock      (clock),
        .rstn       (rstn),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_write  (req_write),
        .req_addr   (req_addr),
        .req_funct3 (req_funct3),
        .req_wdata  (req_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_rdata  (rsp_rdata),
        .rsp_error  (rsp_error)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    // Drives one complete request/response transaction and reports the
    // response plus the number of edges from accept to rsp_valid.
    task automatic apply_stimulus(input logic w, input logic [31:0] a, input logic [2:0] f3,
                                  input logic [31:0] wd, output logic [31:0] rd,
                                  output logic er, output int lat);
        int n;
        @(negedge clock);
        req_valid  = 1'b1;
        req_write  = w;
        req_addr   = a;
        req_funct3 = f3;
        req_wdata  = wd;
        n = 0;
        while (req_ready !== 1'b1 && n < 50) begin
            @(negedge clock);
            n++;
        end
        @(posedge clock);
        #1;
        req_valid = 1'b0;
        lat = 0;
        while (rsp_valid !== 1'b1 && lat < 50) begin
            @(posedge clock);
            #1;
            lat++;
        end
        vectors++;
        if (lat >= 50) begin
            miscompares++;
            $display("[TB] FAIL xfer_timeout addr=%h: got no rsp_valid within %0d edges, expected response", a, lat);
        end
        rd = rsp_rdata;
        er = rsp_error;
        rsp_ready = 1'b1;
        @(posedge clock);
        #1;
        rsp_ready = 1'b0;
    endtask

    task automatic test_reset;
        rstn = 1'b1;
        #1 rstn = 1'b0;
        repeat (3) @(negedge clock);
        vectors++;
        if (req_ready !== 1'b0 || rsp_valid !== 1'b0 || rsp_error !== 1'b0 || rsp_rdata !== 32'h0) begin
            miscompares++;
            $display("[TB] FAIL reset_outputs: got rr=%b rv=%b re=%b rd=%h, expected all zero",
                     req_ready, rsp_valid, rsp_error, rsp_rdata);
        end
        rstn = 1'b1;
        #1;
        vectors++;
        if (req_ready !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL reset_release_ready: got %b, expected 0 before first edge", req_ready);
        end
        @(posedge clock);
        #1;
        vectors++;
        if (req_ready !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL reset_first_edge_ready: got %b, expected 1", req_ready);
        end
    endtask

    task automatic test_word_access;
        logic [31:0] rd;
        logic        er;
        int          lat;
        apply_stimulus(1'b1, 32'h10, 3'b010, 32'hDEADBEEF, rd, er, lat);
        vectors++;
        if (rd !== 32'h0 || er !== 1'b0 || lat !== 3) begin
            miscompares++;
            $display("[TB] FAIL sw_10: got rd=%h er=%b lat=%0d, expected rd=0 er=0 lat=3", rd, er, lat);
        end
        apply_stimulus(1'b0, 32'h10, 3'b010, 32'h0, rd, er, lat);
        vectors++;
        if (rd !== 32'hDEADBEEF || er !== 1'b0 || lat !== 3) begin
            miscompares++;
            $display("[TB] FAIL lw_10: got rd=%h er=%b lat=%0d, expected rd=deadbeef er=0 lat=3", rd, er, lat);
        end
        apply_stimulus(1'b0, 32'h1010, 3'b010, 32'h0, rd, er, lat);
        vectors++;
        if (rd !== 32'hDEADBEEF || er !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL lw_wrap_1010: got rd=%h er=%b, expected rd=deadbeef er=0", rd, er);
        end
    endtask

    task automatic test_load_extension;
        logic [31:0] rd;
        logic        er;
        int          lat;
        logic [31:0] addr_tab [6];
        logic [2:0]  f3_tab   [6];
        logic [31:0] exp_tab  [6];
        addr_tab = '{32'h21, 32'h23, 32'h23, 32'h22, 32'h22, 32'h20};
        f3_tab   = '{3'b000, 3'b100, 3'b000, 3'b001, 3'b101, 3'b001};
        exp_tab  = '{32'h00000060, 32'h00000080, 32'hFFFFFF80, 32'hFFFF8070, 32'h00008070, 32'h00006050};
        apply_stimulus(1'b1, 32'h20, 3'b010, 32'h80706050, rd, er, lat);
        for (int i = 0; i < 6; i++) begin
            apply_stimulus(1'b0, addr_tab[i], f3_tab[i], 32'h0, rd, er, lat);
            vectors++;
            if (rd !== exp_tab[i] || er !== 1'b0) begin
                miscompares++;
                $display("[TB] FAIL load_ext[%0d] addr=%h f3=%b: got rd=%h er=%b, expected rd=%h er=0",
                         i, addr_tab[i], f3_tab[i], rd, er, exp_tab[i]);
            end
        end
    endtask

    task automatic test_partial_stores;
        logic [31:0] rd;
        logic        er;
        int          lat;
        apply_stimulus(1'b1, 32'h20, 3'b010, 32'h11223344, rd, er, lat);
        apply_stimulus(1'b1, 32'h21, 3'b000, 32'h000000AA, rd, er, lat);
        vectors++;
        if (rd !== 32'h0 || er !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL sb_21_rsp: got rd=%h er=%b, expected rd=0 er=0", rd, er);
        end
        apply_stimulus(1'b0, 32'h20, 3'b010, 32'h0, rd, er, lat);
        vectors++;
        if (rd !== 32'h1122AA44) begin
            miscompares++;
            $display("[TB] FAIL sb_21_merge: got %h, expected 1122aa44", rd);
        end
        apply_stimulus(1'b1, 32'h22, 3'b001, 32'hFFFF5555, rd, er, lat);
        apply_stimulus(1'b0, 32'h20, 3'b010, 32'h0, rd, er, lat);
        vectors++;
        if (rd !== 32'h5555AA44) begin
            miscompares++;
            $display("[TB] FAIL sh_22_merge: got %h, expected 5555aa44", rd);
        end
    endtask

    task automatic test_errors;
        logic [31:0] rd;
        logic        er;
        int          lat;
        apply_stimulus(1'b0, 32'h22, 3'b010, 32'h0, rd, er, lat);
        vectors++;
        if (rd !== 32'h0 || er !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL lw_misaligned_22: got rd=%h er=%b, expected rd=0 er=1", rd, er);
        end
        apply_stimulus(1'b1, 32'h00, 3'b010, 32'hCAFEF00D, rd, er, lat);
        apply_stimulus(1'b1, 32'h01, 3'b001, 32'h00001234, rd, er, lat);
        vectors++;
        if (rd !== 32'h0 || er !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL sh_misaligned_01: got rd=%h er=%b, expected rd=0 er=1", rd, er);
        end
        apply_stimulus(1'b0, 32'h03, 3'b101, 32'h0, rd, er, lat);
        vectors++;
        if (rd !== 32'h0 || er !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL lhu_misaligned_03: got rd=%h er=%b, expected rd=0 er=1", rd, er);
        end
        apply_stimulus(1'b0, 32'h00, 3'b011, 32'h0, rd, er, lat);
        vectors++;
        if (rd !== 32'h0 || er !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL load_f3_011: got rd=%h er=%b, expected rd=0 er=1", rd, er);
        end
        apply_stimulus(1'b1, 32'h00, 3'b100, 32'h000000FF, rd, er, lat);
        vectors++;
        if (er !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL store_f3_100: got er=%b, expected er=1", er);
        end
        apply_stimulus(1'b0, 32'h00, 3'b010, 32'h0, rd, er, lat);
        vectors++;
        if (rd !== 32'hCAFEF00D || er !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL word_0_unchanged: got rd=%h er=%b, expected rd=cafef00d er=0", rd, er);
        end
    endtask

    task automatic test_backpressure;
        logic [31:0] rd;
        logic        er;
        int          lat;
        @(negedge clock);
        req_valid  = 1'b1;
        req_write  = 1'b0;
        req_addr   = 32'h10;
        req_funct3 = 3'b010;
        req_wdata  = 32'h0;
        @(posedge clock);
        #1;
        // Keep presenting a store that must be ignored while busy.
        req_write = 1'b1;
        lat = 0;
        while (rsp_valid !== 1'b1 && lat < 50) begin
            @(posedge clock);
            #1;
            lat++;
        end
        vectors++;
        if (lat !== 3) begin
            miscompares++;
            $display("[TB] FAIL bp_latency: got %0d edges, expected 3", lat);
        end
        for (int c = 0; c < 5; c++) begin
            @(posedge clock);
            #1;
            vectors++;
            if (rsp_valid !== 1'b1 || rsp_rdata !== 32'hDEADBEEF || req_ready !== 1'b0) begin
                miscompares++;
                $display("[TB] FAIL bp_hold[%0d]: got rv=%b rd=%h rr=%b, expected rv=1 rd=deadbeef rr=0",
                         c, rsp_valid, rsp_rdata, req_ready);
            end
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        @(posedge clock);
        #1;
        rsp_ready = 1'b0;
        vectors++;
        if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL bp_release: got rv=%b rr=%b, expected rv=0 rr=1", rsp_valid, req_ready);
        end
        apply_stimulus(1'b0, 32'h10, 3'b010, 32'h0, rd, er, lat);
        vectors++;
        if (rd !== 32'hDEADBEEF) begin
            miscompares++;
            $display("[TB] FAIL bp_store_ignored: got %h, expected deadbeef", rd);
        end
    endtask

    task automatic test_back_to_back;
        int first;
        int second;
        first  = -1;
        second = -1;
        rsp_ready = 1'b1;
        @(negedge clock);
        req_valid  = 1'b1;
        req_write  = 1'b0;
        req_addr   = 32'h10;
        req_funct3 = 3'b010;
        for (int c = 0; c < 40 && second < 0; c++) begin
            if (c > 0) @(negedge clock);
            if (req_ready === 1'b1) begin
                if (first < 0) first = c;
                else           second = c;
            end
        end
        req_valid = 1'b0;
        rsp_ready = 1'b0;
        vectors++;
        if (first < 0 || second - first !== 5) begin
            miscompares++;
            $display("[TB] FAIL issue_interval: got first=%0d second=%0d, expected spacing 5", first, second);
        end
        repeat (6) @(posedge clock);
        rsp_ready = 1'b1;
        @(posedge clock);
        #1;
        rsp_ready = 1'b0;
    endtask

    task automatic test_reset_recovery;
        logic [31:0] rd;
        logic        er;
        int          lat;
        apply_stimulus(1'b1, 32'h30, 3'b010, 32'hA5A5A5A5, rd, er, lat);
        apply_stimulus(1'b0, 32'h30, 3'b010, 32'h0, rd, er, lat);
        @(negedge clock);
        req_valid  = 1'b1;
        req_write  = 1'b1;
        req_addr   = 32'h30;
        req_funct3 = 3'b010;
        req_wdata  = 32'h12345678;
        @(posedge clock);
        #1;
        req_valid = 1'b0;
        @(posedge clock);
        #3 rstn = 1'b0;
        #1;
        vectors++;
        if (req_ready !== 1'b0 || rsp_valid !== 1'b0 || rsp_rdata !== 32'h0 || rsp_error !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL reset_mid_wait: got rr=%b rv=%b rd=%h re=%b, expected all zero",
                     req_ready, rsp_valid, rsp_rdata, rsp_error);
        end
        repeat (2) @(negedge clock);
        rstn = 1'b1;
        @(posedge clock);
        #1;
        vectors++;
        if (req_ready !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL reset_recover_ready: got %b, expected 1", req_ready);
        end
        apply_stimulus(1'b0, 32'h30, 3'b010, 32'h0, rd, er, lat);
        vectors++;
        if (rd !== 32'hA5A5A5A5 || er !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL store_dropped_30: got rd=%h er=%b, expected rd=a5a5a5a5 er=0", rd, er);
        end
        @(negedge clock);
        req_valid  = 1'b1;
        req_write  = 1'b0;
        req_addr   = 32'h30;
        req_funct3 = 3'b010;
        @(posedge clock);
        #1;
        req_valid = 1'b0;
        lat = 0;
        while (rsp_valid !== 1'b1 && lat < 50) begin
            @(posedge clock);
            #1;
            lat++;
        end
        #2 rstn = 1'b0;
        #1;
        vectors++;
        if (rsp_valid !== 1'b0 || rsp_rdata !== 32'h0) begin
            miscompares++;
            $display("[TB] FAIL reset_in_resp: got rv=%b rd=%h, expected rv=0 rd=0", rsp_valid, rsp_rdata);
        end
        repeat (2) @(negedge clock);
        rstn = 1'b1;
        repeat (2) @(posedge clock);
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rstn        = 1'b1;
        req_valid   = 1'b0;
        req_write   = 1'b0;
        req_addr    = 32'h0;
        req_funct3  = 3'b000;
        req_wdata   = 32'h0;
        rsp_ready   = 1'b0;
        test_reset();
        test_word_access();
        test_load_extension();
        test_partial_stores();
        test_errors();
        test_backpressure();
        test_back_to_back();
        test_reset_recovery();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
